// File: rtl/klotski_grid_encoder.sv
// Klotski board pixel source: draws the 64-bit block order as an 8x8 grid of red cells on 800x600 VGA timing.
// Optional macro GRID_OVERLAY_EN adds green tile outlines without touching the red channel.
module klotski_grid_encoder #(
    parameter int          H_SYNC_TOTAL = 1056,
    parameter int          V_SYNC_TOTAL = 628,
    parameter int          LEFT_ORIGIN  = 155,
    parameter int          UP_ORIGIN    = 46,
    parameter int          CELL_W       = 70,
    parameter int          CELL_H       = 68,
    parameter logic [23:0] ON_COLOR     = 24'hFF0000,
    parameter logic [23:0] OFF_COLOR    = 24'h000000,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic        i_Clk,
    input  logic        i_rst_n,
    input  logic        i_Load,
    input  logic [63:0] i_block_order,
    input  logic [12:0] i_H_Counter,
    input  logic [12:0] i_V_Counter,
    output logic [7:0]  o_Red,
    output logic [7:0]  o_Green,
    output logic [7:0]  o_Blue,
    output logic        o_busy,
    output logic        o_frame_done
);

    localparam logic [12:0] HLast    = 13'(H_SYNC_TOTAL - 1);
    localparam logic [12:0] VLast    = 13'(V_SYNC_TOTAL - 1);
    localparam logic [12:0] HOrigin  = 13'(LEFT_ORIGIN);
    localparam logic [12:0] VOrigin  = 13'(UP_ORIGIN);
    localparam logic [6:0]  SubWLast = 7'(CELL_W - 1);
    localparam logic [6:0]  SubHLast = 7'(CELL_H - 1);
    localparam logic [3:0]  IdxOut   = 4'd8;

    typedef enum logic [1:0] {S_IDLE, S_WAIT_FRAME, S_ACTIVE} state_e;

    state_e      state_q, state_d;
    logic        frameStart, renderEn;
    logic [63:0] shadow_q, active_q;

    logic [6:0]  colSub_q, colSub_d, colSubCur;
    logic [3:0]  colIdx_q, colIdx_d, colIdxCur;
    logic [6:0]  rowSub_q, rowSub_d, rowSubCur;
    logic [3:0]  rowIdx_q, rowIdx_d, rowIdxCur;

    logic        inGrid_q, render_q, last_q;
    logic [5:0]  cellSel_q;
    logic [5:0]  bitSel;
    logic [23:0] pixel_d, rgb_q;
`ifdef GRID_OVERLAY_EN
    logic        outline_q;
`endif

    assign frameStart = (i_H_Counter == 13'd0) && (i_V_Counter == 13'd0);

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:       if (i_Load) state_d = S_WAIT_FRAME;
            S_WAIT_FRAME: if (frameStart) state_d = S_ACTIVE;
            S_ACTIVE:     state_d = S_ACTIVE;
            default:      state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy   = (state_q != S_IDLE);
        renderEn = (state_q == S_ACTIVE);
    end

    // Active order only changes on the frame-start pixel, so a frame never tears.
    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            shadow_q <= '0;
            active_q <= '0;
        end else begin
            if (i_Load) shadow_q <= i_block_order;
            if (frameStart && (state_q != S_IDLE)) active_q <= shadow_q;
        end
    end

    // The stored counters predict the next pixel/line; the origin compare overrides them.
    always_comb begin
        colSubCur = (i_H_Counter == HOrigin) ? 7'd0 : colSub_q;
        colIdxCur = (i_H_Counter == HOrigin) ? 4'd0 : colIdx_q;
        colSub_d  = colSubCur + 7'd1;
        colIdx_d  = colIdxCur;
        if (colIdxCur >= IdxOut) begin
            colSub_d = '0;
            colIdx_d = IdxOut;
        end else if (colSubCur == SubWLast) begin
            colSub_d = '0;
            colIdx_d = colIdxCur + 4'd1;
        end

        rowSubCur = (i_V_Counter == VOrigin) ? 7'd0 : rowSub_q;
        rowIdxCur = (i_V_Counter == VOrigin) ? 4'd0 : rowIdx_q;
        rowSub_d  = rowSubCur + 7'd1;
        rowIdx_d  = rowIdxCur;
        if (rowIdxCur >= IdxOut) begin
            rowSub_d = '0;
            rowIdx_d = IdxOut;
        end else if (rowSubCur == SubHLast) begin
            rowSub_d = '0;
            rowIdx_d = rowIdxCur + 4'd1;
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            colSub_q <= '0;
            colIdx_q <= IdxOut;
            rowSub_q <= '0;
            rowIdx_q <= IdxOut;
        end else begin
            colSub_q <= colSub_d;
            colIdx_q <= colIdx_d;
            if (i_H_Counter == HLast) begin
                rowSub_q <= rowSub_d;
                rowIdx_q <= rowIdx_d;
            end
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            inGrid_q  <= 1'b0;
            render_q  <= 1'b0;
            last_q    <= 1'b0;
            cellSel_q <= '0;
`ifdef GRID_OVERLAY_EN
            outline_q <= 1'b0;
`endif
        end else begin
            inGrid_q  <= (colIdxCur < IdxOut) && (rowIdxCur < IdxOut);
            render_q  <= renderEn;
            last_q    <= renderEn && (i_H_Counter == HLast) && (i_V_Counter == VLast);
            cellSel_q <= {rowIdxCur[2:0], colIdxCur[2:0]};
`ifdef GRID_OVERLAY_EN
            outline_q <= (colIdxCur[0] && (colSubCur == SubWLast)) ||
                         (rowIdxCur[0] && (rowSubCur == SubHLast));
`endif
        end
    end

    // Tile t=4j+k sits at bits [63-4t -: 4]; inverting {j,k,rowLsb,colLsb} yields the bit index.
    always_comb begin
        bitSel  = ~{cellSel_q[5:4], cellSel_q[2:1], cellSel_q[3], cellSel_q[0]};
        pixel_d = BG_COLOR;
        if (render_q && inGrid_q) begin
            pixel_d = active_q[bitSel] ? ON_COLOR : OFF_COLOR;
`ifdef GRID_OVERLAY_EN
            if (outline_q) pixel_d[15:8] = 8'h80;
`endif
        end
    end

    always_ff @(posedge i_Clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rgb_q        <= '0;
            o_frame_done <= 1'b0;
        end else begin
            rgb_q        <= pixel_d;
            o_frame_done <= last_q;
        end
    end

    assign o_Red   = rgb_q[23:16];
    assign o_Green = rgb_q[15:8];
    assign o_Blue  = rgb_q[7:0];

endmodule

// File: tb/tb_klotski_grid_encoder.sv
// Scoreboard bench for klotski_grid_encoder: directed pixels push expected colours, a negedge monitor pops them.
// Lines without checkpoints are shortened to their end-of-line pixel to keep frames short.
module tb_klotski_grid_encoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load;
    logic [63:0] order;
    logic [12:0] hCnt, vCnt;
    logic [7:0]  oRed, oGreen, oBlue;
    logic        oBusy, oDone;

    klotski_grid_encoder dut (
        .i_Clk        (clk),
        .i_rst_n      (rst_n),
        .i_Load       (load),
        .i_block_order(order),
        .i_H_Counter  (hCnt),
        .i_V_Counter  (vCnt),
        .o_Red        (oRed),
        .o_Green      (oGreen),
        .o_Blue       (oBlue),
        .o_busy       (oBusy),
        .o_frame_done (oDone)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          h;
        int          v;
        logic [23:0] rgb;
        logic        done;
        logic        busy;
        string       name;
    } checkpoint_t;

    typedef struct {
        int          due;
        logic [23:0] rgb;
        logic        done;
        logic        busy;
        string       name;
    } sbEntry_t;

    checkpoint_t cpList[$];
    sbEntry_t    sbQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          doneCount  = 0;

    logic        loadArm  = 1'b0;
    int          loadH, loadV;
    logic [63:0] loadVal;
    logic        resetArm = 1'b0;
    int          resetH, resetV;

`ifdef GRID_OVERLAY_EN
    localparam logic [23:0] ExpOutlineOn = 24'hFF8000;
`else
    localparam logic [23:0] ExpOutlineOn = 24'hFF0000;
`endif

    task automatic checkOutput(input string name, input logic [23:0] expRgb,
                               input logic expDone, input logic expBusy);
        logic [23:0] act;
        act = {oRed, oGreen, oBlue};
        compared++;
        if (act !== expRgb || oDone !== expDone || oBusy !== expBusy) begin
            mismatched++;
            $display("[TB] FAIL %s: got rgb=%06h done=%b busy=%b, expected rgb=%06h done=%b busy=%b",
                     name, act, oDone, oBusy, expRgb, expDone, expBusy);
        end
    endtask

    task automatic addCp(input int h, input int v, input logic [23:0] rgb,
                         input logic done, input logic busy, input string name);
        checkpoint_t c;
        c.h = h; c.v = v; c.rgb = rgb; c.done = done; c.busy = busy; c.name = name;
        cpList.push_back(c);
    endtask

    // Present one pixel; its colour is due two clock edges after the edge that samples it.
    task automatic applyStimulus(input int h, input int v);
        sbEntry_t e;
        @(posedge clk);
        #1;
        hCnt = 13'(h);
        vCnt = 13'(v);
        load = loadArm && (h == loadH) && (v == loadV);
        if (load) order = loadVal;
        foreach (cpList[i]) begin
            if (cpList[i].h == h && cpList[i].v == v) begin
                e.due  = cyc + 2;
                e.rgb  = cpList[i].rgb;
                e.done = cpList[i].done;
                e.busy = cpList[i].busy;
                e.name = cpList[i].name;
                sbQ.push_back(e);
            end
        end
        if (resetArm && (h == resetH) && (v == resetV)) begin
            #2 rst_n = 1'b0;
            #1 checkOutput("async_reset_mid_frame", 24'h000000, 1'b0, 1'b0);
            sbQ.delete();
            @(posedge clk);
            @(posedge clk);
            #1 rst_n = 1'b1;
        end
    endtask

    task automatic sweepFrame();
        logic full;
        for (int v = 0; v < 628; v++) begin
            full = 1'b0;
            foreach (cpList[i]) if (cpList[i].v == v && cpList[i].h != 1055) full = 1'b1;
            if ((loadArm && loadV == v) || (resetArm && resetV == v)) full = 1'b1;
            if (v == 0) applyStimulus(0, 0);
            if (full) for (int h = 150; h <= 720; h++) applyStimulus(h, v);
            applyStimulus(1055, v);
        end
    endtask

    always @(negedge clk) begin
        sbEntry_t e;
        while (sbQ.size() > 0 && sbQ[0].due <= cyc) begin
            e = sbQ.pop_front();
            checkOutput(e.name, e.rgb, e.done, e.busy);
        end
        if (oDone === 1'b1) doneCount++;
    end

    initial begin
        #3000000;
        $display("[TB] FAIL watchdog: simulation did not finish, compared=%0d", compared);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        load  = 1'b0;
        order = '0;
        hCnt  = '0;
        vCnt  = '0;
        repeat (3) @(posedge clk);
        #1 checkOutput("reset_state", 24'h000000, 1'b0, 1'b0);
        rst_n = 1'b1;

        loadArm = 1'b1; loadH = 1055; loadV = 627; loadVal = 64'h8000_0000_0000_0000;
        applyStimulus(1055, 627);

        // Frame 1: single tile-0 cell lit; a mid-frame load of all ones must not show yet.
        loadH = 400; loadV = 300; loadVal = 64'hFFFF_FFFF_FFFF_FFFF;
        addCp(0,    0,   24'h000000, 1'b0, 1'b1, "f1_origin");
        addCp(154,  46,  24'h000000, 1'b0, 1'b1, "f1_left_of_grid");
        addCp(155,  46,  24'hFF0000, 1'b0, 1'b1, "f1_cell00_on");
        addCp(225,  46,  24'h000000, 1'b0, 1'b1, "f1_cell01_off");
        addCp(155,  114, 24'h000000, 1'b0, 1'b1, "f1_cell10_off");
        addCp(155,  318, 24'h000000, 1'b0, 1'b1, "f1_no_midframe_swap");
        addCp(1055, 627, 24'h000000, 1'b1, 1'b1, "f1_frame_done");
        sweepFrame();

        // Frame 2: all ones, grid edges; load the bottom-right tile mid-frame.
        cpList.delete();
        loadVal = 64'h0000_0000_0000_000F;
        addCp(154,  46,  24'h000000,   1'b0, 1'b1, "f2_left_bg");
        addCp(155,  46,  24'hFF0000,   1'b0, 1'b1, "f2_first_pixel");
        addCp(294,  46,  ExpOutlineOn, 1'b0, 1'b1, "f2_tile_edge_col");
        addCp(295,  46,  24'hFF0000,   1'b0, 1'b1, "f2_after_tile_edge");
        addCp(714,  589, ExpOutlineOn, 1'b0, 1'b1, "f2_last_grid_pixel");
        addCp(715,  589, 24'h000000,   1'b0, 1'b1, "f2_right_bg");
        addCp(714,  590, 24'h000000,   1'b0, 1'b1, "f2_below_bg");
        addCp(155,  318, 24'hFF0000,   1'b0, 1'b1, "f2_old_image_kept");
        addCp(1055, 627, 24'h000000,   1'b1, 1'b1, "f2_frame_done");
        sweepFrame();

        // Frame 3: bottom-right tile only; a load coincident with the swap lands next frame.
        cpList.delete();
        loadH = 0; loadV = 0; loadVal = 64'h8000_0000_0000_0000;
        addCp(155,  46,  24'h000000, 1'b0, 1'b1, "f3_cell00_off");
        addCp(575,  454, 24'hFF0000, 1'b0, 1'b1, "f3_cell66_on");
        addCp(645,  522, 24'hFF0000, 1'b0, 1'b1, "f3_cell77_on");
        addCp(505,  454, 24'h000000, 1'b0, 1'b1, "f3_cell65_off");
        addCp(575,  452, 24'h000000, 1'b0, 1'b1, "f3_cell56_off");
        addCp(1055, 627, 24'h000000, 1'b1, 1'b1, "f3_frame_done");
        sweepFrame();

        cpList.delete();
        loadArm = 1'b0;
        addCp(155,  46,  24'hFF0000, 1'b0, 1'b1, "f4_coincident_load_shown");
        addCp(575,  454, 24'h000000, 1'b0, 1'b1, "f4_cell66_off");
        addCp(1055, 627, 24'h000000, 1'b1, 1'b1, "f4_frame_done");
        sweepFrame();

        // Frame 5: reset mid-frame; frame 6 must stay idle and dark.
        cpList.delete();
        resetArm = 1'b1; resetH = 400; resetV = 300;
        sweepFrame();
        resetArm = 1'b0;
        addCp(155,  46,  24'h000000, 1'b0, 1'b0, "f6_idle_bg");
        addCp(1055, 627, 24'h000000, 1'b0, 1'b0, "f6_no_frame_done");
        sweepFrame();

        repeat (5) @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (sbQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_drain: %0d entries left, expected 0", sbQ.size());
        end
        compared++;
        if (doneCount != 4) begin
            mismatched++;
            $display("[TB] FAIL frame_done_count: got %0d pulses, expected 4", doneCount);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
